// File: rtl/imem_fetch_scheduler_b2b.sv
// Purpose : splits a program fetch into bursts of up to BLOCK_BEATS beats, one burst per imem half-buffer.
// Latency : read beat -> imem write beat 1 cycle; last write -> imem_wr_done 1 cycle; done -> fetch_done 1 cycle.
// Backpr. : rd_req/rd_addr/rd_req_beats held stable until rd_ready; each block stalls in WAIT_BUF until imem_wr_start.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start, genesys_done   begin a fetch (latches inst_base_addr/inst_total_beats); abort any fetch
//   fetch_busy/fetch_done busy from accepted start to completion/abort; 1-cycle completion pulse
//   rd_req/rd_ready       burst request handshake with rd_addr (bytes) and rd_req_beats
//   rd_data_valid/rd_data read beats from the AXI read master
//   imem_wr_start         imem half-buffer free, block may be fetched
//   imem_wr_data_valid/imem_wr_data/imem_wr_done  registered write stream into imem, block close pulse
//   perf_wait_cycles      cycles spent waiting for imem_wr_start
//
// Optional feature: define IMEM_FETCH_PERF_EN to build the perf_wait_cycles counter;
// without it perf_wait_cycles is constant 0.

module imem_fetch_scheduler_b2b #(
  parameter int NUM_INST_IN     = 2,
  parameter int INST_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH  = 42,
  parameter int BLOCK_BEATS     = 512,
  parameter int CNT_W           = 16,
  localparam int BW             = NUM_INST_IN * INST_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      genesys_done,
  input  logic [AXI_ADDR_WIDTH-1:0] inst_base_addr,
  input  logic [CNT_W-1:0]          inst_total_beats,
  output logic                      fetch_busy,
  output logic                      fetch_done,
  output logic                      rd_req,
  input  logic                      rd_ready,
  output logic [AXI_ADDR_WIDTH-1:0] rd_addr,
  output logic [CNT_W-1:0]          rd_req_beats,
  input  logic                      rd_data_valid,
  input  logic [BW-1:0]             rd_data,
  input  logic                      imem_wr_start,
  output logic                      imem_wr_data_valid,
  output logic [BW-1:0]             imem_wr_data,
  output logic                      imem_wr_done,
  output logic [31:0]               perf_wait_cycles
);

  localparam logic [CNT_W-1:0]          BLK_MAX    = CNT_W'(BLOCK_BEATS);
  localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(BW / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BUF,
    S_REQ,
    S_DATA,
    S_BLK_DONE,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  // Fetch context
  logic [AXI_ADDR_WIDTH-1:0] addr_q;      // byte address of the next burst
  logic [CNT_W-1:0]          rem_q;       // beats still to be requested
  logic [CNT_W-1:0]          blk_q;       // length of the burst in flight
  logic [CNT_W-1:0]          beat_cnt_q;  // beats received for the current burst

  // Registered write stream and pulses
  logic                      wr_vld_q;
  logic [BW-1:0]             wr_dat_q;
  logic                      wr_done_q;
  logic                      fetch_done_q;

  // Decoded events
  logic                      abort;
  logic                      start_acc;
  logic                      req_hs;
  logic                      beat_acc;
  logic [CNT_W-1:0]          req_beats;
  logic [CNT_W-1:0]          beat_cnt_inc;
  logic [CNT_W-1:0]          rem_after;
  logic [AXI_ADDR_WIDTH-1:0] addr_after;

  // Abort has priority over every other event in the same cycle.
  assign abort     = genesys_done && (state != S_IDLE);
  assign start_acc = start && (state == S_IDLE);
  assign req_hs    = (state == S_REQ) && rd_ready && !abort;
  // Beats arriving outside DATA, or in the abort cycle, are discarded.
  assign beat_acc  = (state == S_DATA) && rd_data_valid && !abort;

  assign req_beats    = (rem_q > BLK_MAX) ? BLK_MAX : rem_q;
  assign beat_cnt_inc = beat_cnt_q + CNT_W'(1);
  assign rem_after    = rem_q - blk_q;
  // Address arithmetic wraps naturally at AXI_ADDR_WIDTH bits.
  assign addr_after   = addr_q + (AXI_ADDR_WIDTH'(blk_q) * BEAT_BYTES);

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (inst_total_beats == '0) ? S_FIN : S_WAIT_BUF;
        end
      end
      S_WAIT_BUF: begin
        if (imem_wr_start) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (rd_ready) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (rd_data_valid && (beat_cnt_inc == blk_q)) begin
          state_nxt = S_BLK_DONE;
        end
      end
      S_BLK_DONE: begin
        state_nxt = (rem_after == '0) ? S_FIN : S_WAIT_BUF;
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
    end
  end

  // ------------------------------------------------------------------
  // State and datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      blk_q        <= '0;
      beat_cnt_q   <= '0;
      wr_vld_q     <= 1'b0;
      wr_dat_q     <= '0;
      wr_done_q    <= 1'b0;
      fetch_done_q <= 1'b0;
    end else begin
      state <= state_nxt;

      if (start_acc) begin
        addr_q <= inst_base_addr;
        rem_q  <= inst_total_beats;
      end

      if (req_hs) begin
        blk_q      <= req_beats;
        beat_cnt_q <= '0;
      end else if (beat_acc) begin
        beat_cnt_q <= beat_cnt_inc;
      end

      // Advance to the next block once the current one is closed.
      if ((state == S_BLK_DONE) && !abort) begin
        addr_q <= addr_after;
        rem_q  <= rem_after;
      end

      wr_vld_q <= beat_acc;
      if (beat_acc) begin
        wr_dat_q <= rd_data;
      end

      // The pulses are registered from their state so that imem_wr_done
      // lands one cycle after the last registered write beat.
      wr_done_q    <= (state == S_BLK_DONE) && !abort;
      fetch_done_q <= (state == S_FIN) && !abort;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign fetch_busy         = (state != S_IDLE);
  assign fetch_done         = fetch_done_q;
  assign rd_req             = (state == S_REQ);
  assign rd_addr            = rd_req ? addr_q : '0;
  assign rd_req_beats       = rd_req ? req_beats : '0;
  assign imem_wr_data_valid = wr_vld_q;
  assign imem_wr_data       = wr_dat_q;
  assign imem_wr_done       = wr_done_q;

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= '0;
    end else if ((state == S_WAIT_BUF) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_wait_cycles = perf_q;
`else
  assign perf_wait_cycles = 32'd0;
`endif

endmodule
